// File: rtl/ibex_pkg.sv
// Shared types and limits for the instruction prefetch request engine.
package ibex_pkg;

    typedef enum logic [0:0] {
        PF_IDLE     = 1'b0,
        PF_WAIT_GNT = 1'b1
    } prefetch_state_e;

    localparam int unsigned PF_MAX_REQS = 4;

    function automatic logic [2:0] pf_popcount(input logic [PF_MAX_REQS-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < PF_MAX_REQS; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/ibex_prefetch_rsp_tracker.sv
// Outstanding-response tracker: pending/discard shift vectors, oldest entry at bit 0.
module ibex_prefetch_rsp_tracker
    import ibex_pkg::*;
#(
    parameter int unsigned NUM_REQS = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  logic       push_discard_i,
    input  logic       pop_i,
    input  logic       branch_i,
    output logic [2:0] cnt_o,
    output logic       pend_any_o,
    output logic       oldest_discard_o
);

    logic [NUM_REQS-1:0]    pend_q, disc_q;
    logic [NUM_REQS-1:0]    pend_s, disc_s;
    logic [NUM_REQS-1:0]    pend_d, disc_d;
    logic [PF_MAX_REQS-1:0] pend_x, pend_sx;
    logic [2:0]             cnt_s;

    always_comb begin
        pend_x  = '0;
        pend_sx = '0;
        pend_s  = pop_i ? (pend_q >> 1) : pend_q;
        disc_s  = pop_i ? (disc_q >> 1) : disc_q;
        // A branch poisons every entry still waiting after this cycle's pop.
        if (branch_i) disc_s = disc_s | pend_s;
        pend_x[NUM_REQS-1:0]  = pend_q;
        pend_sx[NUM_REQS-1:0] = pend_s;
        cnt_s  = pf_popcount(pend_sx);
        pend_d = pend_s;
        disc_d = disc_s;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (push_i && cnt_s == 3'(i)) begin
                pend_d[i] = 1'b1;
                disc_d[i] = push_discard_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q <= '0;
            disc_q <= '0;
        end else begin
            pend_q <= pend_d;
            disc_q <= disc_d;
        end
    end

    assign cnt_o            = pf_popcount(pend_x);
    assign pend_any_o       = |pend_q;
    assign oldest_discard_o = disc_q[0];

endmodule

// File: rtl/ibex_prefetch_ctrl.sv
// Instruction fetch request engine feeding ibex_fetch_fifo.
// Optional IBEX_PREFETCH_ERR_STOP_EN halts fetching after a bus error until a branch.
module ibex_prefetch_ctrl
    import ibex_pkg::*;
#(
    parameter int unsigned NUM_REQS = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    output logic        busy_o,
    output logic        instr_req_o,
    input  logic        instr_gnt_i,
    output logic [31:0] instr_addr_o,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    output logic        fifo_clear_o,
    output logic        fifo_valid_o,
    input  logic        fifo_ready_i,
    output logic [31:0] fifo_addr_o,
    output logic [31:0] fifo_rdata_o,
    output logic        fifo_err_o
);

    localparam logic [0:0] IDLE     = PF_IDLE;
    localparam logic [0:0] WAIT_GNT = PF_WAIT_GNT;

    if (NUM_REQS < 1 || NUM_REQS > PF_MAX_REQS) begin : g_bad_param
        $error("NUM_REQS out of range");
    end

    logic [0:0]  state_q;
    logic [31:0] fetch_addr_q, req_addr_q, tgt;
    logic        branch_seen_q, in_wait, gnt_acc, push_discard;
    logic        pop, can_issue, stop, pend_any, oldest_disc;
    logic [2:0]  cnt, cnt_eff;

    assign tgt      = {branch_addr_i[31:2], 2'b00};
    assign in_wait  = (state_q == WAIT_GNT);
    assign pop      = instr_rvalid_i & pend_any;
    assign cnt_eff  = cnt - {2'b00, pop};
    assign can_issue = req_i & fifo_ready_i & ~stop
                     & (cnt_eff < 3'(NUM_REQS));

    always_comb begin
        instr_req_o  = can_issue;
        instr_addr_o = branch_i ? tgt : fetch_addr_q;
        if (in_wait) begin
            instr_req_o  = 1'b1;
            instr_addr_o = req_addr_q;
        end
    end

    assign gnt_acc      = instr_req_o & instr_gnt_i;
    assign push_discard = in_wait & (branch_seen_q | branch_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            fetch_addr_q  <= '0;
            req_addr_q    <= '0;
            branch_seen_q <= 1'b0;
        end else begin
            if (!in_wait && instr_req_o && !instr_gnt_i) begin
                state_q    <= WAIT_GNT;
                req_addr_q <= instr_addr_o;
            end else if (in_wait && instr_gnt_i) begin
                state_q <= IDLE;
            end
            if (gnt_acc)                  branch_seen_q <= 1'b0;
            else if (in_wait && branch_i) branch_seen_q <= 1'b1;
            // An IDLE branch granted this cycle already consumed the target word.
            if (branch_i)
                fetch_addr_q <= tgt + ((!in_wait && gnt_acc) ? 32'd4 : 32'd0);
            else if (gnt_acc && !push_discard)
                fetch_addr_q <= fetch_addr_q + 32'd4;
        end
    end

`ifdef IBEX_PREFETCH_ERR_STOP_EN
    logic err_stop_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                            err_stop_q <= 1'b0;
        else if (branch_i)                    err_stop_q <= 1'b0;
        else if (fifo_valid_o && instr_err_i) err_stop_q <= 1'b1;
    end
    assign stop = err_stop_q & ~branch_i;
`else
    assign stop = 1'b0;
`endif

    ibex_prefetch_rsp_tracker #(.NUM_REQS(NUM_REQS)) u_tracker (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .push_i          (gnt_acc),
        .push_discard_i  (push_discard),
        .pop_i           (pop),
        .branch_i        (branch_i),
        .cnt_o           (cnt),
        .pend_any_o      (pend_any),
        .oldest_discard_o(oldest_disc)
    );

    assign busy_o       = in_wait | pend_any;
    assign fifo_clear_o = branch_i;
    assign fifo_addr_o  = branch_addr_i;
    assign fifo_valid_o = instr_rvalid_i & ~oldest_disc & ~branch_i;
    assign fifo_rdata_o = instr_rdata_i;
    assign fifo_err_o   = instr_err_i;

    a_rvalid_pend: assert property (@(posedge clk_i) disable iff (rst_i)
        instr_rvalid_i |-> pend_any);
    a_addr_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (instr_req_o && !instr_gnt_i) |=> (instr_req_o && $stable(instr_addr_o)));
    a_issue_ready: assert property (@(posedge clk_i) disable iff (rst_i)
        (!in_wait && instr_req_o) |-> fifo_ready_i);

endmodule
